multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 105 ++++++++++
 rtl/multicycle_control_classifier.sv | 43 ++++
 rtl/multicycle_control.sv | 169 ++++++++++++++++
 tb/tb_multicycle_control.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multicycle controller: states, instruction classes,
// opcode patterns, control codes and the per-class EXEC decode table.
package multicycle_control_pkg;

    localparam int OP_BITS = 11;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CL_R     = 4'd0,  CL_RS    = 4'd1,  CL_I     = 4'd2,  CL_IS    = 4'd3,
        CL_CMP   = 4'd4,  CL_CMPI  = 4'd5,  CL_LOAD  = 4'd6,  CL_STORE = 4'd7,
        CL_CBZ   = 4'd8,  CL_CBNZ  = 4'd9,  CL_B     = 4'd10, CL_BCOND = 4'd11,
        CL_ILLEGAL = 4'd12
    } op_class_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_PASS  = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [2:0] BR_NONE   = 3'b000;
    localparam logic [2:0] BR_UNCOND = 3'b001;
    localparam logic [2:0] BR_COND   = 3'b010;
    localparam logic [2:0] BR_CBZ    = 3'b011;
    localparam logic [2:0] BR_CBNZ   = 3'b100;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_IMEM    = 2'b10;
    localparam logic [1:0] FC_DMEM    = 2'b11;

    // Opcode values; the masks mark which bits are significant for that format.
    localparam logic [OP_BITS-1:0] M_R  = 11'b111_1111_1111;
    localparam logic [OP_BITS-1:0] M_I  = 11'b111_1111_1110;
    localparam logic [OP_BITS-1:0] M_CB = 11'b111_1111_1000;
    localparam logic [OP_BITS-1:0] M_B  = 11'b111_1110_0000;

    localparam logic [OP_BITS-1:0] OP_ADD   = 11'b100_0101_1000;
    localparam logic [OP_BITS-1:0] OP_SUB   = 11'b110_0101_1000;
    localparam logic [OP_BITS-1:0] OP_AND   = 11'b100_0101_0000;
    localparam logic [OP_BITS-1:0] OP_ORR   = 11'b101_0101_0000;
    localparam logic [OP_BITS-1:0] OP_ADDS  = 11'b101_0101_1000;
    localparam logic [OP_BITS-1:0] OP_ANDS  = 11'b111_0101_0000;
    localparam logic [OP_BITS-1:0] OP_SUBS  = 11'b111_0101_1000;
    localparam logic [OP_BITS-1:0] OP_ADDI  = 11'b100_1000_1000;
    localparam logic [OP_BITS-1:0] OP_SUBI  = 11'b110_1000_1000;
    localparam logic [OP_BITS-1:0] OP_ADDIS = 11'b101_1000_1000;
    localparam logic [OP_BITS-1:0] OP_SUBIS = 11'b111_1000_1000;
    localparam logic [OP_BITS-1:0] OP_LDUR  = 11'b111_1100_0010;
    localparam logic [OP_BITS-1:0] OP_STUR  = 11'b111_1100_0000;
    localparam logic [OP_BITS-1:0] OP_CBZ   = 11'b101_1010_0000;
    localparam logic [OP_BITS-1:0] OP_CBNZ  = 11'b101_1010_1000;
    localparam logic [OP_BITS-1:0] OP_B     = 11'b000_1010_0000;
    localparam logic [OP_BITS-1:0] OP_BCOND = 11'b010_1010_0000;

    typedef struct packed {
        logic       alu_src;
        logic [1:0] alu_op;
        logic       readreg2;
        logic       update_sreg;
        logic [2:0] branch_op;
    } exec_ctrl_t;

    function automatic logic op_match(input logic [OP_BITS-1:0] op,
                                      input logic [OP_BITS-1:0] val,
                                      input logic [OP_BITS-1:0] mask);
        return ((op ^ val) & mask) == '0;
    endfunction

    function automatic exec_ctrl_t exec_ctrl(input op_class_t c);
        exec_ctrl_t x;
        x = '0;
        case (c)
            CL_R:             x.alu_op = ALU_FUNCT;
            CL_RS, CL_CMP:    begin x.alu_op = ALU_FUNCT; x.update_sreg = 1'b1; end
            CL_I:             begin x.alu_src = 1'b1; x.alu_op = ALU_FUNCT; end
            CL_IS, CL_CMPI:   begin x.alu_src = 1'b1; x.alu_op = ALU_FUNCT; x.update_sreg = 1'b1; end
            CL_LOAD:          x.alu_src = 1'b1;
            CL_STORE:         begin x.alu_src = 1'b1; x.readreg2 = 1'b1; end
            CL_CBZ:           begin x.alu_op = ALU_PASS; x.readreg2 = 1'b1; x.branch_op = BR_CBZ; end
            CL_CBNZ:          begin x.alu_op = ALU_PASS; x.readreg2 = 1'b1; x.branch_op = BR_CBNZ; end
            CL_B:             begin x.alu_op = ALU_PASS; x.branch_op = BR_UNCOND; end
            CL_BCOND:         begin x.alu_op = ALU_PASS; x.branch_op = BR_COND; end
            default:          x = '0;
        endcase
        return x;
    endfunction

    function automatic logic branch_taken(input op_class_t c, input logic flags_taken);
        case (c)
            CL_B:           return 1'b1;
            CL_BCOND,
            CL_CBZ:         return flags_taken;
            CL_CBNZ:        return !flags_taken;
            default:        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_classifier.sv
// Combinational opcode-to-class decode; anything not listed is ILLEGAL.
module opcode_classifier
    import multicycle_control_pkg::*;
#(
    parameter int OPCODE_W = 11
) (
    input  logic [OPCODE_W-1:0] opcode,
    output op_class_t           op_class
);

    logic [OP_BITS-1:0] op;
    assign op = opcode[OPCODE_W-1 -: OP_BITS];

    always_comb begin
        op_class = CL_ILLEGAL;
        if (op_match(op, OP_ADD, M_R) || op_match(op, OP_SUB, M_R) ||
            op_match(op, OP_AND, M_R) || op_match(op, OP_ORR, M_R))
            op_class = CL_R;
        else if (op_match(op, OP_ADDS, M_R) || op_match(op, OP_ANDS, M_R))
            op_class = CL_RS;
        else if (op_match(op, OP_SUBS, M_R))
            op_class = CL_CMP;
        else if (op_match(op, OP_ADDI, M_I) || op_match(op, OP_SUBI, M_I))
            op_class = CL_I;
        else if (op_match(op, OP_ADDIS, M_I))
            op_class = CL_IS;
        else if (op_match(op, OP_SUBIS, M_I))
            op_class = CL_CMPI;
        else if (op_match(op, OP_LDUR, M_R))
            op_class = CL_LOAD;
        else if (op_match(op, OP_STUR, M_R))
            op_class = CL_STORE;
        else if (op_match(op, OP_CBZ, M_CB))
            op_class = CL_CBZ;
        else if (op_match(op, OP_CBNZ, M_CB))
            op_class = CL_CBNZ;
        else if (op_match(op, OP_B, M_B))
            op_class = CL_B;
        else if (op_match(op, OP_BCOND, M_CB))
            op_class = CL_BCOND;
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB controller with memory-handshake timeouts
// and a sticky FAULT state. All control outputs are registered.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int OPCODE_W    = 11,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    input  logic                flags_taken,
    output logic                pc_write,
    output logic                ir_write,
    output logic                imem_req,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                alu_src,
    output logic [1:0]          alu_op,
    output logic                update_sreg,
    output logic                readreg2_control,
    output logic [2:0]          branch_op,
    output logic                fault,
    output logic [1:0]          fault_code,
    output logic                busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t     state;
    op_class_t  cls_d, cls_q;
    exec_ctrl_t ex_d;
    logic [CNT_W-1:0] cnt;

    opcode_classifier #(.OPCODE_W(OPCODE_W)) u_classifier (
        .opcode   (opcode),
        .op_class (cls_d)
    );

    assign ex_d = exec_ctrl(cls_d);
    assign busy = (state != ST_FETCH);

    // Each edge computes the next state together with the outputs that state
    // presents, so outputs change only with state and never glitch on opcode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_FETCH;
            cls_q            <= CL_ILLEGAL;
            cnt              <= '0;
            pc_write         <= 1'b0;
            ir_write         <= 1'b0;
            imem_req         <= 1'b0;
            mem_read         <= 1'b0;
            mem_write        <= 1'b0;
            mem_to_reg       <= 1'b0;
            reg_write        <= 1'b0;
            alu_src          <= 1'b0;
            alu_op           <= ALU_ADD;
            update_sreg      <= 1'b0;
            readreg2_control <= 1'b0;
            branch_op        <= BR_NONE;
            fault            <= 1'b0;
            fault_code       <= FC_NONE;
        end else begin
            pc_write         <= 1'b0;
            ir_write         <= 1'b0;
            imem_req         <= 1'b0;
            mem_read         <= 1'b0;
            mem_write        <= 1'b0;
            mem_to_reg       <= 1'b0;
            reg_write        <= 1'b0;
            alu_src          <= 1'b0;
            alu_op           <= ALU_ADD;
            update_sreg      <= 1'b0;
            readreg2_control <= 1'b0;
            branch_op        <= BR_NONE;
            case (state)
                ST_FETCH: begin
                    // The first cycle out of reset only raises the request;
                    // ready is honoured only while a request is outstanding.
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ready) begin
                        state    <= ST_DECODE;
                        ir_write <= 1'b1;
                        pc_write <= 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        state      <= ST_FAULT;
                        fault      <= 1'b1;
                        fault_code <= FC_IMEM;
                    end else begin
                        cnt      <= cnt + CNT_W'(1);
                        imem_req <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    cls_q <= cls_d;
                    if (cls_d == CL_ILLEGAL) begin
                        state      <= ST_FAULT;
                        fault      <= 1'b1;
                        fault_code <= FC_ILLEGAL;
                    end else begin
                        state            <= ST_EXEC;
                        alu_src          <= ex_d.alu_src;
                        alu_op           <= ex_d.alu_op;
                        readreg2_control <= ex_d.readreg2;
                        update_sreg      <= ex_d.update_sreg;
                        branch_op        <= ex_d.branch_op;
                        pc_write         <= branch_taken(cls_d, flags_taken);
                    end
                end
                ST_EXEC: begin
                    cnt <= '0;
                    case (cls_q)
                        CL_R, CL_RS, CL_I, CL_IS: begin
                            state     <= ST_WB;
                            reg_write <= 1'b1;
                        end
                        CL_LOAD: begin
                            state    <= ST_MEM;
                            mem_read <= 1'b1;
                        end
                        CL_STORE: begin
                            state     <= ST_MEM;
                            mem_write <= 1'b1;
                        end
                        default: begin
                            state    <= ST_FETCH;
                            imem_req <= 1'b1;
                        end
                    endcase
                end
                ST_MEM: begin
                    if (dmem_ready) begin
                        if (cls_q == CL_LOAD) begin
                            state      <= ST_WB;
                            reg_write  <= 1'b1;
                            mem_to_reg <= 1'b1;
                        end else begin
                            state    <= ST_FETCH;
                            imem_req <= 1'b1;
                            cnt      <= '0;
                        end
                    end else if (cnt == CNT_LAST) begin
                        state      <= ST_FAULT;
                        fault      <= 1'b1;
                        fault_code <= FC_DMEM;
                    end else begin
                        cnt       <= cnt + CNT_W'(1);
                        mem_read  <= (cls_q == CL_LOAD);
                        mem_write <= (cls_q == CL_STORE);
                    end
                end
                ST_WB: begin
                    state    <= ST_FETCH;
                    imem_req <= 1'b1;
                    cnt      <= '0;
                end
                default: state <= ST_FAULT;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: stimulus pushes hand-written per-cycle output vectors,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] opcode = '0;
    logic        imem_ready = 1'b0, dmem_ready = 1'b0, flags_taken = 1'b0;
    logic        pc_write, ir_write, imem_req, mem_read, mem_write, mem_to_reg, reg_write;
    logic        alu_src, update_sreg, readreg2_control, fault, busy;
    logic [1:0]  alu_op, fault_code;
    logic [2:0]  branch_op;

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .flags_taken(flags_taken),
        .pc_write(pc_write), .ir_write(ir_write), .imem_req(imem_req),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src(alu_src), .alu_op(alu_op),
        .update_sreg(update_sreg), .readreg2_control(readreg2_control),
        .branch_op(branch_op), .fault(fault), .fault_code(fault_code), .busy(busy)
    );

    always #5 clk = ~clk;

    // Field order: pcw irw ireq mrd mwr m2r rw asrc aop[2] upd rr2 br[3] flt fc[2] busy
    logic [18:0] obs;
    assign obs = {pc_write, ir_write, imem_req, mem_read, mem_write, mem_to_reg, reg_write,
                  alu_src, alu_op, update_sreg, readreg2_control, branch_op,
                  fault, fault_code, busy};

    localparam logic [18:0] V_RST     = 19'b0_0_0_0_0_0_0_0_00_0_0_000_0_00_0;
    localparam logic [18:0] V_FETCH   = 19'b0_0_1_0_0_0_0_0_00_0_0_000_0_00_0;
    localparam logic [18:0] V_DEC     = 19'b1_1_0_0_0_0_0_0_00_0_0_000_0_00_1;
    localparam logic [18:0] V_WB      = 19'b0_0_0_0_0_0_1_0_00_0_0_000_0_00_1;
    localparam logic [18:0] V_WB_LD   = 19'b0_0_0_0_0_1_1_0_00_0_0_000_0_00_1;
    localparam logic [18:0] V_MRD     = 19'b0_0_0_1_0_0_0_0_00_0_0_000_0_00_1;
    localparam logic [18:0] V_MWR     = 19'b0_0_0_0_1_0_0_0_00_0_0_000_0_00_1;
    localparam logic [18:0] V_F_ILL   = 19'b0_0_0_0_0_0_0_0_00_0_0_000_1_01_1;
    localparam logic [18:0] V_F_IMEM  = 19'b0_0_0_0_0_0_0_0_00_0_0_000_1_10_1;
    localparam logic [18:0] V_F_DMEM  = 19'b0_0_0_0_0_0_0_0_00_0_0_000_1_11_1;
    localparam logic [18:0] E_ADD     = 19'b0_0_0_0_0_0_0_0_10_0_0_000_0_00_1;
    localparam logic [18:0] E_ADDI    = 19'b0_0_0_0_0_0_0_1_10_0_0_000_0_00_1;
    localparam logic [18:0] E_CMP     = 19'b0_0_0_0_0_0_0_0_10_1_0_000_0_00_1;
    localparam logic [18:0] E_LD      = 19'b0_0_0_0_0_0_0_1_00_0_0_000_0_00_1;
    localparam logic [18:0] E_ST      = 19'b0_0_0_0_0_0_0_1_00_0_1_000_0_00_1;
    localparam logic [18:0] E_CBNZ_T  = 19'b1_0_0_0_0_0_0_0_01_0_1_100_0_00_1;
    localparam logic [18:0] E_CBNZ_N  = 19'b0_0_0_0_0_0_0_0_01_0_1_100_0_00_1;
    localparam logic [18:0] E_B_T     = 19'b1_0_0_0_0_0_0_0_01_0_0_001_0_00_1;
    localparam logic [18:0] E_BC_N    = 19'b0_0_0_0_0_0_0_0_01_0_0_010_0_00_1;
    localparam logic [18:0] E_CBZ_T   = 19'b1_0_0_0_0_0_0_0_01_0_1_011_0_00_1;

    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_ADDI = 11'b10010001001;
    localparam logic [10:0] OPC_SUBS = 11'b11101011000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [10:0] OPC_CBNZ = 11'b10110101101;
    localparam logic [10:0] OPC_CBZ  = 11'b10110100010;
    localparam logic [10:0] OPC_B    = 11'b00010110110;
    localparam logic [10:0] OPC_BC   = 11'b01010100011;

    typedef struct {
        string       name;
        logic [18:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (obs === e.v) n_pass++;
            else $display("FAIL %s: got %b, expected %b", e.name, obs, e.v);
        end
    end

    task automatic expect_n(input string name, input logic [18:0] v, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.name = name;
            e.v    = v;
            exp_q.push_back(e);
        end
    endtask

    // Reset the DUT; returns just after reset is released, inside the reset cycle.
    task automatic start(input logic [10:0] op, input logic ir, input logic dr, input logic fl);
        opcode = op; imem_ready = ir; dmem_ready = dr; flags_taken = fl;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic prologue(input string name);
        expect_n({name, " reset"},  V_RST,   1);
        expect_n({name, " fetch"},  V_FETCH, 1);
        expect_n({name, " decode"}, V_DEC,   1);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        if (exp_q.size() > 0) begin
            n_chk++;
            $display("FAIL %s drain: %0d expectations left, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic simple(input string name, input logic [10:0] op, input logic fl,
                          input logic [18:0] ex, input logic has_wb);
        start(op, 1'b1, 1'b1, fl);
        prologue(name);
        expect_n({name, " exec"}, ex, 1);
        if (has_wb) expect_n({name, " wb"}, V_WB, 1);
        expect_n({name, " next_fetch"}, V_FETCH, 1);
        drain(name);
    endtask

    initial begin
        simple("add",       OPC_ADD,  1'b0, E_ADD,    1'b1);
        simple("addi",      OPC_ADDI, 1'b0, E_ADDI,   1'b1);
        simple("cmp",       OPC_SUBS, 1'b0, E_CMP,    1'b0);
        simple("cbnz_f0",   OPC_CBNZ, 1'b0, E_CBNZ_T, 1'b0);
        simple("cbnz_f1",   OPC_CBNZ, 1'b1, E_CBNZ_N, 1'b0);
        simple("b_f0",      OPC_B,    1'b0, E_B_T,    1'b0);
        simple("b_f1",      OPC_B,    1'b1, E_B_T,    1'b0);
        simple("bcond_f0",  OPC_BC,   1'b0, E_BC_N,   1'b0);
        simple("cbz_f1",    OPC_CBZ,  1'b1, E_CBZ_T,  1'b0);

        // LDUR, dmem_ready arrives in the 4th MEM cycle
        start(OPC_LDUR, 1'b1, 1'b0, 1'b0);
        prologue("ldur");
        expect_n("ldur exec", E_LD, 1);
        expect_n("ldur mem",  V_MRD, 4);
        expect_n("ldur wb",   V_WB_LD, 1);
        expect_n("ldur next_fetch", V_FETCH, 1);
        repeat (7) @(posedge clk);
        #1 dmem_ready = 1'b1;
        drain("ldur");

        // STUR, dmem never ready: 16 MEM cycles then absorbing fault
        start(OPC_STUR, 1'b1, 1'b0, 1'b0);
        prologue("stur_to");
        expect_n("stur_to exec",  E_ST, 1);
        expect_n("stur_to mem",   V_MWR, 16);
        expect_n("stur_to fault", V_F_DMEM, 3);
        drain("stur_to");

        // STUR, ready on the last allowed MEM cycle wins over the timeout
        start(OPC_STUR, 1'b1, 1'b0, 1'b0);
        prologue("stur_edge");
        expect_n("stur_edge exec", E_ST, 1);
        expect_n("stur_edge mem",  V_MWR, 16);
        expect_n("stur_edge next_fetch", V_FETCH, 1);
        repeat (19) @(posedge clk);
        #1 dmem_ready = 1'b1;
        drain("stur_edge");

        // imem never ready: 16 request cycles then fault 10
        start(OPC_ADD, 1'b0, 1'b1, 1'b0);
        expect_n("imem_to reset", V_RST, 1);
        expect_n("imem_to fetch", V_FETCH, 16);
        expect_n("imem_to fault", V_F_IMEM, 2);
        drain("imem_to");

        // Illegal opcode faults right after DECODE
        start(11'b0, 1'b1, 1'b1, 1'b0);
        prologue("illegal");
        expect_n("illegal fault", V_F_ILL, 2);
        drain("illegal");

        // Reset during MEM, then a normal fetch
        start(OPC_LDUR, 1'b1, 1'b0, 1'b0);
        prologue("rst_mem");
        expect_n("rst_mem exec", E_LD, 1);
        expect_n("rst_mem mem",  V_MRD, 2);
        expect_n("rst_mem reset_again", V_RST, 1);
        expect_n("rst_mem refetch", V_FETCH, 1);
        expect_n("rst_mem redecode", V_DEC, 1);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        drain("rst_mem");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
